uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 131 +++++++++++++
 tb/tb_uart_tx_frame.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmit framer. Accepts one parallel word per handshake and serializes
// it onto TX_OUT at one bit per CLK cycle (CLK is the TX baud clock).
// The frame is:
//   - start bit (0);
//   - DATA_WIDTH data bits, LSB first;
//   - an optional parity bit;
//   - one stop bit (1).
// At least one idle cycle always separates consecutive frames.
//
// Parameters
//   DATA_WIDTH  bits per word / data bits per frame (legal 5..9)
//
// Ports
//   CLK         in   TX baud clock, rising-edge
//   RST         in   synchronous, active-high reset
//   P_DATA      in   word to send, sampled at accept only
//   Data_Valid  in   request to send P_DATA (honoured only when idle)
//   PAR_EN      in   1 = append parity bit, sampled at accept only
//   PAR_TYP     in   0 = even, 1 = odd parity, sampled at accept only
//   TX_OUT      out  registered serial line, idles high
//   Busy        out  registered, high for every cycle of a frame
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;   // parity enable latched at accept
  logic                  par_bit_q;  // parity bit computed at accept

  // TX_OUT and Busy are loaded with the value belonging to the state being
  // entered, so they change exactly on the edge the state changes and never
  // depend combinationally on the inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          if (Data_Valid) begin
            shift_reg <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
            bit_cnt   <= '0;
            TX_OUT    <= 1'b0;  // start bit
            Busy      <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          // Present data bit 0 for the first DATA cycle.
          TX_OUT    <= shift_reg[0];
          shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
          state     <= DATA;
        end

        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            // Last data bit is on the line now; counter is held so it never
            // wraps for widths that are a power of two.
            if (par_en_q) begin
              TX_OUT <= par_bit_q;
              state  <= PARITY;
            end else begin
              TX_OUT <= 1'b1;
              state  <= STOP;
            end
          end else begin
            TX_OUT    <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end

        PARITY: begin
          TX_OUT <= 1'b1;  // stop bit
          state  <= STOP;
        end

        STOP: begin
          // Always return through IDLE: guarantees the one-cycle gap and
          // keeps Data_Valid from being seen while the stop bit is out.
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_DATA = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          TX_OUT;
  logic          Busy;

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: one expected {tx, busy} sample per cycle after each edge.
  logic [1:0] exp_q[$];
  // Model: line bits still to send for the frame in flight.
  logic       pend[$];
  logic       m_busy = 1'b0;   // expected Busy during the cycle now ending
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         done    = 1'b0;

  // Reference model: a frame is just a list of line bits built from the word.
  task automatic model_step(input logic rst, input logic dv, input logic [DW-1:0] d,
                            input logic pen, input logic pt);
    logic b;
    if (rst) begin
      pend.delete();
      m_busy = 1'b0;
      exp_q.push_back(2'b10);
    end else if (dv && !m_busy) begin
      for (int i = 0; i < DW; i++) pend.push_back(d[i]);
      if (pen) begin
        b = 1'b0;
        for (int i = 0; i < DW; i++) b = b ^ d[i];
        pend.push_back(b ^ pt);
      end
      pend.push_back(1'b1);
      m_busy = 1'b1;
      exp_q.push_back(2'b01);          // start bit
    end else if (pend.size() > 0) begin
      b = pend.pop_front();
      m_busy = 1'b1;
      exp_q.push_back({b, 1'b1});
    end else begin
      m_busy = 1'b0;
      exp_q.push_back(2'b10);
    end
  endtask

  task automatic cycle(input logic rst, input logic dv, input logic [DW-1:0] d,
                       input logic pen, input logic pt);
    @(negedge CLK);
    RST = rst; Data_Valid = dv; P_DATA = d; PAR_EN = pen; PAR_TYP = pt;
    model_step(rst, dv, d, pen, pt);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, P_DATA, PAR_EN, PAR_TYP);
  endtask

  // Monitor: compare the line after every edge that has an expectation.
  initial begin : monitor
    logic [1:0] e;
    int cyc;
    cyc = 0;
    while (!done) begin
      @(posedge CLK);
      #2;
      cyc++;
      if (!done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (TX_OUT !== e[1] || Busy !== e[0]) begin
          n_fail++;
          $display("FAIL line cyc=%0d got tx=%b busy=%b expected tx=%b busy=%b",
                   cyc, TX_OUT, Busy, e[1], e[0]);
        end
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] rd;
    // Reset, then start a frame and reset it mid-flight for two cycles.
    cycle(1, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 0, 0);
    cycle(0, 1, 8'h5A, 1, 1);
    hold(4);
    cycle(1, 0, 8'h5A, 1, 1);
    cycle(1, 0, 8'h5A, 1, 1);
    hold(4);
    // 0xA5 without parity, then with even and odd parity.
    cycle(0, 1, 8'hA5, 0, 0); hold(13);
    cycle(0, 1, 8'hA5, 1, 0); hold(13);
    cycle(0, 1, 8'hA5, 1, 1); hold(13);
    // Back-to-back with Data_Valid held high: 0x00 odd then 0xFF even.
    cycle(0, 1, 8'h00, 1, 1);
    for (int i = 0; i < 12; i++) cycle(0, 1, 8'hFF, 1, 0);
    cycle(0, 0, 8'hFF, 1, 0); hold(13);
    // Inputs change right after accept; mid-frame Data_Valid is ignored.
    cycle(0, 1, 8'h3C, 1, 0);
    cycle(0, 1, 8'hC3, 0, 0);
    hold(14);
    // Reset landing on the parity cycle, accept on the edge reset drops.
    cycle(0, 1, 8'h81, 1, 0);
    hold(9);
    cycle(1, 0, 8'h81, 1, 0);
    cycle(1, 0, 8'h81, 1, 0);
    cycle(0, 1, 8'h7E, 1, 1);
    hold(14);
    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rd = DW'($urandom);
      cycle(($urandom_range(63) == 0), ($urandom_range(2) != 0), rd,
            1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    hold(15);
    @(posedge CLK);
    #3;
    done = 1'b1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound so the run ends even if the clocking logic stalls.
  initial begin : watchdog
    #2000000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
